// File: rtl/seg7_scan4.sv
// ----------------------------------------------------------------------------
// seg7_scan4 : 4-digit multiplexed 7-segment driver for a packed-BCD SS.cc count
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seg7_scan4 #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        blink,
  input  logic        lzb_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int P_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [P_W-1:0]  P_LAST  = P_W'(SCAN_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);
  localparam logic [6:0]      SEG_OFF = 7'b1111111;

  logic [P_W-1:0]  p_q, p_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     snap_q, snap_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic            phase_q, phase_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            frame_tick_q, frame_tick_d;

  logic            tc;
  logic            boundary;
  logic [3:0]      digit;
  logic            blanked;
  logic            lit;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  // Scan timing, frame snapshot and blink phase.
  always_comb begin
    tc           = (p_q == P_LAST);
    boundary     = tc && (idx_q == 2'd3);
    p_d          = tc ? '0 : p_q + P_W'(1);
    idx_d        = tc ? idx_q + 2'd1 : idx_q;
    snap_d       = boundary ? bcd_in : snap_q;
    frame_tick_d = boundary;
    bc_d         = bc_q;
    phase_d      = phase_q;
    if (!blink) begin
      bc_d    = '0;
      phase_d = 1'b1;
    end else if (boundary) begin
      if (bc_q == BC_LAST) begin
        bc_d    = '0;
        phase_d = ~phase_q;
      end else begin
        bc_d = bc_q + BC_W'(1);
      end
    end
  end

  // Output decode; a low blink input bypasses the phase so it relights at once.
  always_comb begin
    case (idx_q)
      2'd0:    digit = snap_q[3:0];
      2'd1:    digit = snap_q[7:4];
      2'd2:    digit = snap_q[11:8];
      default: digit = snap_q[15:12];
    endcase
    blanked = (idx_q == 2'd3) && lzb_en && (snap_q[15:12] == 4'd0);
    lit     = !blanked && (phase_q || !blink);
    an_d    = 4'b1111;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    if (lit) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = seg_decode(digit);
      dp_d  = (idx_q != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p_q          <= '0;
      idx_q        <= 2'd0;
      snap_q       <= 16'h0000;
      bc_q         <= '0;
      phase_q      <= 1'b1;
      an_q         <= 4'b1111;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      p_q          <= p_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      bc_q         <= bc_d;
      phase_q      <= phase_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan4.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan4 : directed self-checking bench for seg7_scan4 (SCAN_DIV=4, BLINK_FRAMES=2)
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seg7_scan4;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S6   = 7'b0000010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] S9   = 7'b0010000;
  localparam logic [6:0] SD   = 7'b0111111;
  localparam logic [6:0] SOFF = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic        blink;
  logic        lzb_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;

  seg7_scan4 #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .blink      (blink),
    .lzb_en     (lzb_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n cycles of one slot; frame_tick expected only on the last cycle when ft_last
  task automatic run_slot(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                          input logic e_dp, input logic ft_last, input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      check({tag, ".an"},  32'(an),  32'(e_an));
      check({tag, ".seg"}, 32'(seg), 32'(e_seg));
      check({tag, ".dp"},  32'(dp),  32'(e_dp));
      check({tag, ".ft"},  32'(frame_tick), 32'(ft_last && (c == n - 1)));
    end
  endtask

  task automatic run_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic blank3, input logic dark);
    if (dark) begin
      run_slot({tag, ".d0"}, 4'b1111, SOFF, 1'b1, 1'b0, 4);
      run_slot({tag, ".d1"}, 4'b1111, SOFF, 1'b1, 1'b0, 4);
      run_slot({tag, ".d2"}, 4'b1111, SOFF, 1'b1, 1'b0, 4);
      run_slot({tag, ".d3"}, 4'b1111, SOFF, 1'b1, 1'b1, 4);
    end else begin
      run_slot({tag, ".d0"}, 4'b1110, s0, 1'b1, 1'b0, 4);
      run_slot({tag, ".d1"}, 4'b1101, s1, 1'b1, 1'b0, 4);
      run_slot({tag, ".d2"}, 4'b1011, s2, 1'b0, 1'b0, 4);
      if (blank3)
        run_slot({tag, ".d3"}, 4'b1111, SOFF, 1'b1, 1'b1, 4);
      else
        run_slot({tag, ".d3"}, 4'b0111, s3, 1'b1, 1'b1, 4);
    end
  endtask

  initial begin
    rst    = 1'b0;
    bcd_in = 16'h1234;
    blink  = 1'b0;
    lzb_en = 1'b0;
    tick();
    tick();
    check("rst.an",  32'(an),  32'h0000000f);
    check("rst.seg", 32'(seg), 32'(SOFF));
    check("rst.dp",  32'(dp),  32'h1);
    check("rst.ft",  32'(frame_tick), 32'h0);

    // Basic scan: first frame from snap=0, then the 1234 snapshot
    rst = 1'b1;
    run_frame("f1", S0, S0, S0, S0, 1'b0, 1'b0);
    bcd_in = 16'h5678;
    run_frame("f2", S4, S3, S2, S1, 1'b0, 1'b0);

    // 5678 only after the boundary; queue 0509 with blanking enabled
    bcd_in = 16'h0509;
    lzb_en = 1'b1;
    run_frame("f3", S8, S7, S6, S5, 1'b0, 1'b0);
    run_frame("f4", S9, S0, S5, S0, 1'b1, 1'b0);
    lzb_en = 1'b0;
    bcd_in = 16'hAF00;
    run_frame("f5", S9, S0, S5, S0, 1'b0, 1'b0);
    run_frame("f6", S0, S0, SD, SD, 1'b0, 1'b0);

    // Blink: two lit frames, two dark frames, repeating
    blink = 1'b1;
    run_frame("f7",  S0, S0, SD, SD, 1'b0, 1'b0);
    run_frame("f8",  S0, S0, SD, SD, 1'b0, 1'b0);
    run_frame("f9",  S0, S0, SD, SD, 1'b0, 1'b1);
    run_frame("f10", S0, S0, SD, SD, 1'b0, 1'b1);
    run_frame("f11", S0, S0, SD, SD, 1'b0, 1'b0);
    run_frame("f12", S0, S0, SD, SD, 1'b0, 1'b0);

    // Drop blink in the dark phase: relit on the next cycle
    run_slot("f13.d0",  4'b1111, SOFF, 1'b1, 1'b0, 4);
    run_slot("f13.d1k", 4'b1111, SOFF, 1'b1, 1'b0, 1);
    blink = 1'b0;
    run_slot("f13.d1l", 4'b1101, S0, 1'b1, 1'b0, 3);
    run_slot("f13.d2",  4'b1011, SD, 1'b0, 1'b0, 4);
    run_slot("f13.d3",  4'b0111, SD, 1'b1, 1'b1, 4);

    // Reset mid-slot at idx 2, then the scan restarts from d0 with snap=0
    run_slot("f14.d0", 4'b1110, S0, 1'b1, 1'b0, 4);
    run_slot("f14.d1", 4'b1101, S0, 1'b1, 1'b0, 4);
    run_slot("f14.d2", 4'b1011, SD, 1'b0, 1'b0, 2);
    rst = 1'b0;
    run_slot("mrst", 4'b1111, SOFF, 1'b1, 1'b0, 1);
    rst = 1'b1;
    run_frame("post", S0, S0, S0, S0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_scan4.md
# seg7_scan4

Four-digit multiplexed 7-segment display driver for the stopwatch datapath. It consumes the stopwatch's 16-bit packed BCD count (SS.cc format) and drives one digit at a time with a fixed refresh rate. Inputs are latched once per scan frame so a frame never mixes two count values. It adds leading-zero blanking, a fixed decimal point, invalid-digit indication and a whole-display blink used while the count is frozen. It sits directly downstream of the timer, between its `out` bus and the board's anode/segment pins.

## Interface
- `SCAN_DIV`, default 100000: clock cycles each digit is driven; must be ≥2. The prescaler width is ceil(log2(SCAN_DIV)).
- `BLINK_FRAMES`, default 64: scan frames per blink half-period; must be ≥1.
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `bcd_in` in 16: packed digits {d3,d2,d1,d0}.
  - d3 = `[15:12]` tens of seconds … d0 = `[3:0]` hundredths.
- `blink` in 1: level input. High makes the display blink; low gives steady display.
- `lzb_en` in 1: level input. High enables blanking of d3 when it is 0.
- `an` out 4: digit enables, active-low. `an[i]` selects digit di.
- `seg` out 7: segments, active-low, ordered {g,f,e,d,c,b,a}.
- `dp` out 1: decimal point, active-low.
- `frame_tick` out 1: one-cycle pulse marking a frame boundary (new snapshot).

## Operation
**Prescaler**
- `p` counts 0..SCAN_DIV-1 and wraps to 0.
- tc = (p == SCAN_DIV-1).

**Digit index**
- `idx` is 2 bits. It increments on every tc edge, in the order 0→1→2→3→0.

**Snapshot**
- `snap` (16 bits) loads `bcd_in` on the tc edge where idx==3.
- `bcd_in` is sampled only at that edge; changes at other times are ignored until the next boundary.

**Output register**
- `an`, `seg` and `dp` are registered every cycle from the current idx, `snap`, the blink phase and `lzb_en`.

**Decode (active-low {g..a})**
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Values 10–15 decode to dash 0111111.

**Digit enable**
- `an` = ~(1<<idx) normally.
- Forced to 1111 when:
  - the digit is blanked, or
  - the blink phase is off.
- While `an`=1111, `seg`=1111111 and `dp`=1.

**Leading-zero blank**
- Applies only when idx==3, `lzb_en`=1 and `snap[15:12]`==0.
- d2..d0 are never blanked.

**Decimal point**
- `dp`=0 only when idx==2 and the digit is lit, giving "SS.cc".

**Blink**
- When `blink`=0: frame counter `bc` is held at 0 and the phase is held on.
- When `blink`=1: `bc` counts frame boundaries. When `bc` reaches BLINK_FRAMES-1 at a boundary, `bc` returns to 0 and the phase toggles.
- `blink` going low forces the phase on at the next clock.

**Reset** (`rst`=0 sampled on a clock edge):
- Internal state: p=0, idx=0, snap=0, bc=0, phase=on.
- Outputs: `an`=1111, `seg`=1111111, `dp`=1, `frame_tick`=0.
- Reset mid-frame takes effect on that edge and discards the frame.

## Timing
**Output latency**
- Outputs lag idx and snap by exactly 1 clock.
- Each digit slot lasts exactly SCAN_DIV cycles; a frame is 4·SCAN_DIV cycles.

**First cycles after reset release**
- The first edge with `rst`=1 has p=0.
- One cycle later `an`=1110 and `seg` shows d0 of snap=0 (1000000).

**Snapshot timing**
- The first snapshot is captured at the tc edge with idx==3, which is 4·SCAN_DIV edges after release.
- `frame_tick` is high for the single cycle following that edge, i.e. concurrent with snap update.
- Outputs show the new snapshot starting one cycle after `frame_tick`, on digit 0.

**Simultaneous events**
- tc at idx==3 with `blink` rising: bc increments from 0 on that same boundary.
- `lzb_en` and `blink` changes affect outputs with 1-cycle latency, not deferred to the frame boundary.

**Anode transitions**
- No cycle has two anodes active.
- Between slots, `an` changes in a single clock from one-hot to one-hot, or to/from 1111.

## Test plan
1. SCAN_DIV=4. Reset, release, `bcd_in`=16'h1234, lzb_en=0. Required response:
   - First frame shows 0000.
   - `frame_tick` pulses at cycle 16.
   - Next frame gives d0 `seg`=0011001 (an=1110), d1 0110000, d2 0100100 with dp=0, d3 1111001.
   - Each slot lasts 4 cycles.
2. Change `bcd_in` from 0x1234 to 0x5678 mid-frame. Required response: remaining slots still show 1,2,3,4 digits; 5678 appears only after the next `frame_tick`.
3. `bcd_in`=16'h0509. Required response:
   - With lzb_en=1: slot idx3 gives an=1111, seg=1111111.
   - With lzb_en=0: slot idx3 gives an=0111, seg=1000000.
   - d2=5 is shown with dp=0.
4. `bcd_in`=16'hAF00. Required response: d3 and d2 show 0111111 (dash); d2 dp=0.
5. BLINK_FRAMES=2, SCAN_DIV=4, blink=1. Required response:
   - Lit for 2 frames (32 cycles), then an=1111 for 32 cycles, repeating.
   - Dropping blink during the dark phase relights on the next cycle.
6. Assert `rst`=0 for one cycle mid-slot at idx=2. Required response: next cycle an=1111, seg=1111111, dp=1, frame_tick=0; after release, the scan restarts at d0 with snap=0.
